down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Programmable down-counter/timer for the counter library. It is the decrementing counterpart of the team's up-counting blocks.
- Loaded with a start value, it counts down on each enabled clock and flags terminal count.
- Runs either one-shot or auto-reload (periodic), so control logic can generate delays and periodic ticks.

Parameters:
WIDTH, 4, bit width of count and load value (legal range 2..16)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  load strobe; captures load_val
load_val  input  WIDTH  start/reload value
en  input  1  count enable; decrement only when high
mode  input  1  0 = one-shot, 1 = auto-reload
count  output  WIDTH  current count value (registered)
tc  output  1  terminal-count pulse, one cycle wide (registered)
busy  output  1  high while in RUN
done  output  1  high in DONE (one-shot finished) until next load or reset

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- rst=1 at a rising edge: count=0, reload register=0, tc=0, busy=0, done=0, state=IDLE. Overrides all other inputs, including mid-count.
- State machine (IDLE, RUN, DONE); busy = (state==RUN), done = (state==DONE). Both are derived from registered state.
- Priority at each edge: rst > load > en.
- load=1 (any state): reload register <= load_val; count <= load_val; tc <= 0.
  - If load_val != 0: state <= RUN.
  - If load_val == 0: state <= IDLE, with no tc.
- RUN, load=0, en=0: hold count and state; tc <= 0.
- RUN, load=0, en=1:
  - If count > 1: count <= count-1, tc <= 0.
  - If count == 1, mode sampled at this edge:
    - mode=0: count <= 0, tc <= 1, state <= DONE.
    - mode=1: count <= reload register, tc <= 1, state stays RUN.
- The auto-reload period is exactly N enabled cycles for a reload value of N (count sequence N, N-1, ..., 1, N, ...). tc is high in the cycle after the edge where count==1 was consumed.
- IDLE/DONE, load=0: count held (0 in DONE), tc <= 0, en ignored.
- tc is never high for two consecutive cycles unless the reload value is 1 with mode=1 and en held high; in that case tc is high every cycle and count stays 1.
- Load coinciding with the terminal edge: load wins. No tc, no DONE, count = new load_val.
- No wrap below 0: count never decrements from 0.
- Arithmetic is unsigned, WIDTH bits. Maximum load is 2^WIDTH-1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=1 for 2 cycles with load=1, load_val=9 -> count=0, tc=0, busy=0, done=0. The load is ignored.
- One-shot: load 5, mode=0, en=1 continuously -> count 5,4,3,2,1,0. tc=1 exactly in the cycle count first reads 0. Then done=1, busy=0, count held 0 for 10 more cycles.
- Auto-reload with gaps: load 3, mode=1, en toggling 1,0,1,1,0,1 -> count holds on en=0. After 3 enabled cycles count=3 with tc=1 for one cycle. Repeat 3 periods for exactly 3 tc pulses.
- Corner values:
  - load 1, mode=1, en=1 -> tc high every cycle, count constantly 1.
  - load 0 -> state IDLE, busy=0, no tc.
  - load 15 (WIDTH=4) -> 15 enabled cycles to tc.
- Collisions:
  - Load 7 on the same edge count==1 and en=1 -> count=7, tc=0, busy=1.
  - rst at count=4 mid-run -> count=0 next cycle, no tc.
- Reload from DONE: after one-shot done=1, load 2 -> done=0, busy=1, tc after 2 enabled cycles.

Source files
------------

// File: rtl/down_timer.sv
// down_timer: programmable down counter with one-shot/auto-reload modes and a registered terminal-count pulse
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, count_n;
  logic             term, dec;
  always_comb begin
    term     = !load && state == RUN && en && count == WIDTH'(1);
    dec      = !load && state == RUN && en && count > WIDTH'(1);
    reload_n = load ? load_val : reload;
    count_n  = load ? load_val : term ? (mode ? reload : '0) : dec ? count - WIDTH'(1) : count;
    state_n  = load ? (load_val != '0 ? RUN : IDLE) : (term && !mode) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      tc     <= term;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: scoreboard-driven scenario checks for down_timer
module tb_down_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] count;
  logic       tc, busy, done;
  logic [6:0] q[$];
  logic [6:0] e;
  int         n_cmp = 0;
  int         n_err = 0;
  wire  [6:0] obs = {count, tc, busy, done};
  down_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] mk(input logic [3:0] c, input logic t, b, d);
    return {c, t, b, d};
  endfunction
  task automatic step(input logic r, l, input logic [3:0] lv, input logic n, m);
    rst = r; load = l; load_val = lv; en = n; mode = m;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk(0, 0, 0, 0));
      step(1, 1, 9, 1, 1);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reset[%0d]: got %h want %h ({count,tc,busy,done})", i, obs, e); end
    end
  endtask
  task automatic test_oneshot;
    q.push_back(mk(5, 0, 1, 0));
    step(0, 1, 5, 1, 0);
    e = q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL oneshot_load: got %h want %h", obs, e); end
    for (int i = 1; i <= 15; i++) begin
      q.push_back(i < 5 ? mk(4'(5 - i), 0, 1, 0) : mk(0, i == 5, 0, 1));
      step(0, 0, 0, 1, 0);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL oneshot[%0d]: got %h want %h", i, obs, e); end
    end
  endtask
  task automatic test_autoreload;
    logic       en_p[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] cnt_p[4] = '{4'd2, 4'd2, 4'd1, 4'd3};
    int         tcs = 0;
    q.push_back(mk(3, 0, 1, 0));
    step(0, 1, 3, 0, 1);
    e = q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reload_load: got %h want %h", obs, e); end
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) begin
        q.push_back(mk(cnt_p[k], k == 3, 1, 0));
        step(0, 0, 0, en_p[k], 1);
        tcs += int'(tc);
        e = q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reload[%0d.%0d]: got %h want %h", p, k, obs, e); end
      end
    q.push_back(mk(3, 0, 1, 0));
    step(0, 0, 0, 0, 1);
    e = q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reload_hold: got %h want %h", obs, e); end
    n_cmp++;
    if (tcs != 3) begin n_err++; $display("FAIL reload_tc_pulses: got %0d want 3", tcs); end
  endtask
  task automatic test_corners;
    q.push_back(mk(1, 0, 1, 0));
    step(0, 1, 1, 1, 1);
    e = q.pop_front(); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL one_load: got %h want %h", obs, e); end
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(1, 1, 1, 0));
      step(0, 0, 0, 1, 1);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL one_run[%0d]: got %h want %h", i, obs, e); end
    end
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(0, 0, 0, 0));
      step(0, i == 0, 0, 1, 0);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL zero_load[%0d]: got %h want %h", i, obs, e); end
    end
    for (int i = 0; i <= 15; i++) begin
      q.push_back(i == 0 ? mk(15, 0, 1, 0) : i < 15 ? mk(4'(15 - i), 0, 1, 0) : mk(0, 1, 0, 1));
      step(0, i == 0, 15, 1, 0);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL max_load[%0d]: got %h want %h", i, obs, e); end
    end
  endtask
  task automatic test_collision;
    logic [7:0] stim[8] = '{8'h4D, 8'h02, 8'h02, 8'h5E, 8'h02, 8'h02, 8'h02, 8'h82};
    logic [6:0] exp_t[8];
    exp_t = '{mk(3, 0, 1, 0), mk(2, 0, 1, 0), mk(1, 0, 1, 0), mk(7, 0, 1, 0),
              mk(6, 0, 1, 0), mk(5, 0, 1, 0), mk(4, 0, 1, 0), mk(0, 0, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      q.push_back(exp_t[i]);
      step(stim[i][7], stim[i][6], stim[i][5:2], stim[i][1], stim[i][0]);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL collision[%0d]: got %h want %h", i, obs, e); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] stim[8] = '{8'h4A, 8'h02, 8'h02, 8'h02, 8'h4A, 8'h02, 8'h02, 8'h02};
    logic [6:0] exp_t[8];
    exp_t = '{mk(2, 0, 1, 0), mk(1, 0, 1, 0), mk(0, 1, 0, 1), mk(0, 0, 0, 1),
              mk(2, 0, 1, 0), mk(1, 0, 1, 0), mk(0, 1, 0, 1), mk(0, 0, 0, 1)};
    for (int i = 0; i < 8; i++) begin
      q.push_back(exp_t[i]);
      step(stim[i][7], stim[i][6], stim[i][5:2], stim[i][1], stim[i][0]);
      e = q.pop_front(); n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reload_from_done[%0d]: got %h want %h", i, obs, e); end
    end
  endtask
  initial begin
    test_reset;
    test_oneshot;
    test_autoreload;
    test_corners;
    test_collision;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
